// File: rtl/adc_spi_serializer.sv
// ADC 3-wire SPI serializer: shifts one 24-bit instruction word MSB-first
// while csb is low, turns SDIO around on read frames and returns the data byte.
module adc_spi_serializer #(
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned HDR_BITS   = 16,
  parameter int unsigned RD_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  load,
  input  logic                  csb,
  input  logic [FRAME_BITS-1:0] cfg_word,
  output logic                  adc_csb,
  output logic                  adc_sclk_en,
  output logic                  adc_sdio_o,
  output logic                  adc_sdio_oe,
  input  logic                  adc_sdio_i,
  output logic [RD_BITS-1:0]    rd_data,
  output logic                  rd_valid,
  output logic                  frame_err
);

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned CAP_W   = $clog2(RD_BITS + 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  rd_flag;
  logic [RD_BITS-1:0]    cap_reg;
  logic [CAP_W-1:0]      cap_cnt;
  logic                  rd_pend;

  logic oe_next_c;
  logic frame_end_c;
  logic cap_en_c;

  // Launch/turnaround/capture decisions for the current cycle
  always_comb begin
    oe_next_c   = 1'b1;
    frame_end_c = 1'b0;
    cap_en_c    = 1'b0;
    // header bits always driven; data phase released only on reads
    oe_next_c   = (bit_cnt < CNT_W'(HDR_BITS)) || !rd_flag;
    // registered adc_csb low while csb is high marks the first cycle after a window
    frame_end_c = csb && !adc_csb;
    // bit k (k >= HDR_BITS) is sampled on the edge ending its pin cycle, when bit_cnt = k+1;
    // the last one lands on the frame-end edge with bit_cnt = FRAME_BITS
    cap_en_c    = rd_flag && !adc_csb &&
                  (bit_cnt > CNT_W'(HDR_BITS)) &&
                  (bit_cnt <= CNT_W'(FRAME_BITS)) &&
                  (cap_cnt < CAP_W'(RD_BITS));
  end

  // Shift, capture and frame bookkeeping
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      adc_csb     <= 1'b1;
      adc_sclk_en <= 1'b0;
      adc_sdio_o  <= 1'b0;
      adc_sdio_oe <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      frame_err   <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      rd_flag     <= 1'b0;
      cap_reg     <= '0;
      cap_cnt     <= '0;
      rd_pend     <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_pend   <= 1'b0;

      // publish read data one cycle after a correctly sized read frame closes
      if (rd_pend) begin
        rd_data  <= cap_reg;
        rd_valid <= 1'b1;
      end

      if (cap_en_c) begin
        cap_reg <= {cap_reg[RD_BITS-2:0], adc_sdio_i};
        cap_cnt <= cap_cnt + CAP_W'(1);
      end

      if (!csb) begin
        adc_csb     <= 1'b0;
        adc_sclk_en <= 1'b1;
        adc_sdio_oe <= oe_next_c;
        adc_sdio_o  <= oe_next_c & shreg[FRAME_BITS-1];
        shreg       <= {shreg[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt != CNT_W'(CNT_MAX)) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else begin
        if (frame_end_c) begin
          adc_csb     <= 1'b1;
          adc_sclk_en <= 1'b0;
          adc_sdio_oe <= 1'b0;
          adc_sdio_o  <= 1'b0;
          frame_err   <= (bit_cnt != CNT_W'(FRAME_BITS));
          rd_pend     <= rd_flag && (bit_cnt == CNT_W'(FRAME_BITS));
          // clear so a frame without a preceding load still counts from zero
          bit_cnt     <= '0;
          cap_cnt     <= '0;
        end
        if (load) begin
          shreg   <= cfg_word;
          rd_flag <= cfg_word[FRAME_BITS-1];
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule
